// File: rtl/dac_interpolator_if.sv
// Sample input stream into the DAC interpolator: signed PCM words under a
// valid/ready handshake.
interface dac_interpolator_if #(
    parameter int BW = 16
);
    logic signed [BW-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/dac_interpolator.sv
// Linear-interpolating upsampler: one signed PCM sample in per OSR clocks,
// one interpolated sample out per clock, ramping from x0 towards x1.
module dac_interpolator #(
    parameter int BW       = 16,
    parameter int OSR_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    dac_interpolator_if.slave    s,
    output logic signed [BW-1:0] interp_o,
    output logic                 interp_valid_o,
    output logic                 underrun_o
);

    localparam int AW = BW + OSR_LOG2 + 1;
    localparam logic [OSR_LOG2-1:0] PHASE_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t               state;
    logic signed [BW-1:0] x0;
    logic signed [BW-1:0] x1;
    logic signed [BW-1:0] pend;
    logic                 pend_full;
    logic signed [BW:0]   step;
    logic signed [AW-1:0] acc;
    logic [OSR_LOG2-1:0]  phase;
    logic                 accept;

    // Sample value placed at the start of a period, in accumulator units.
    function automatic logic signed [AW-1:0] scale(input logic signed [BW-1:0] x);
        return AW'(x) <<< OSR_LOG2;
    endfunction

    function automatic logic signed [BW:0] diff(input logic signed [BW-1:0] a,
                                                input logic signed [BW-1:0] b);
        return (BW + 1)'(a) - (BW + 1)'(b);
    endfunction

    // NOTE: rst_n gates ready directly because pend_full alone would read 0 during reset.
    assign s.s_ready = rst_n & ena & ~pend_full;
    assign accept    = s.s_valid & s.s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath is reset as well so interp_o drops to 0 the instant rst_n falls.
        if (!rst_n) begin
            state          <= IDLE;
            x0             <= '0;
            x1             <= '0;
            pend           <= '0;
            pend_full      <= 1'b0;
            step           <= '0;
            acc            <= '0;
            phase          <= '0;
            interp_o       <= '0;
            interp_valid_o <= 1'b0;
            underrun_o     <= 1'b0;
        end else begin
            underrun_o <= 1'b0;
            if (!ena) begin
                interp_valid_o <= 1'b0;
            end else begin
                // Accept and consume never coincide: ready is low whenever pend is full.
                if (accept) begin
                    pend      <= s.s_data;
                    pend_full <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (pend_full) begin
                            x0        <= pend;
                            pend_full <= 1'b0;
                            state     <= PRIME;
                        end
                    end
                    PRIME: begin
                        if (pend_full) begin
                            x1        <= pend;
                            pend_full <= 1'b0;
                            acc       <= scale(x0);
                            step      <= diff(pend, x0);
                            phase     <= '0;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        interp_o       <= BW'(acc >>> OSR_LOG2);
                        interp_valid_o <= 1'b1;
                        if (phase != PHASE_LAST) begin
                            acc   <= acc + AW'(step);
                            phase <= phase + 1'b1;
                        end else begin
                            x0    <= x1;
                            acc   <= scale(x1);
                            phase <= '0;
                            if (pend_full) begin
                                x1        <= pend;
                                pend_full <= 1'b0;
                                step      <= diff(pend, x1);
                            end else begin
                                // Starved: flat-line on x1 until input resumes.
                                step       <= '0;
                                underrun_o <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_interpolator.sv
// Directed bench for dac_interpolator at OSR_LOG2=2 (OSR=4) with hand-computed
// expected sample sequences.
module tb_dac_interpolator;

    localparam int BW       = 16;
    localparam int OSR_LOG2 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic ena   = 1'b0;

    logic signed [BW-1:0] interp_o;
    logic                 interp_valid_o;
    logic                 underrun_o;

    dac_interpolator_if #(.BW(BW)) s_if ();

    dac_interpolator #(
        .BW       (BW),
        .OSR_LOG2 (OSR_LOG2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .s              (s_if),
        .interp_o       (interp_o),
        .interp_valid_o (interp_valid_o),
        .underrun_o     (underrun_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int                   cyc = 0;
    int                   ur_total = 0;
    int                   ur_base = 0;
    logic signed [BW-1:0] outq[$];
    bit                   urq[$];
    logic signed [BW-1:0] accq[$];
    int                   acc_cyc[$];

    // Record handshakes (pre-edge values) and every live output sample.
    always @(posedge clk) begin
        cyc++;
        if (s_if.s_valid && s_if.s_ready) begin
            accq.push_back(s_if.s_data);
            acc_cyc.push_back(cyc);
        end
        #1;
        if (underrun_o) ur_total++;
        if (interp_valid_o) begin
            outq.push_back(interp_o);
            urq.push_back(underrun_o);
        end
    end

    int e_ramp[8]  = '{0, 100, 200, 300, 400, 400, 400, 400};
    int e_down[8]  = '{0, -1, -2, -3, -4, -4, -4, -4};
    // step = 65535, acc starts at -131072: floor((-131072 + k*65535)/4)
    int e_ext[5]   = '{-32768, -16385, -1, 16383, 32767};

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic flush();
        outq.delete();
        urq.delete();
        accq.delete();
        acc_cyc.delete();
        ur_base = ur_total;
    endtask

    // Called at a negedge; returns at a negedge after the sample was taken.
    task automatic push(input int v);
        int n = 0;
        while (!s_if.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", s_if.s_ready, 1);
        s_if.s_valid = 1'b1;
        s_if.s_data  = BW'(v);
        @(negedge clk);
        s_if.s_valid = 1'b0;
    endtask

    task automatic wait_outs(input string tag, input int n);
        int k = 0;
        while (outq.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_outs_avail"}, outq.size() >= n, 1);
    endtask

    task automatic reset_mid(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_interp"}, interp_o, 0);
        check({tag, "_rst_valid"}, interp_valid_o, 0);
        check({tag, "_rst_underrun"}, underrun_o, 0);
        check({tag, "_rst_ready"}, s_if.s_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        flush();
    endtask

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        ena          = 1'b1;

        // Power-on reset
        #1 rst_n = 1'b0;
        #1;
        check("por_interp", interp_o, 0);
        check("por_valid", interp_valid_o, 0);
        check("por_underrun", underrun_o, 0);
        check("por_ready", s_if.s_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        flush();
        #1 check("por_ready_after", s_if.s_ready, 1);

        // Ramp 0 -> 400, then a held 400
        push(0);
        push(400);
        push(400);
        wait_outs("ramp", 12);
        for (int i = 0; i < 8; i++) check($sformatf("ramp_out%0d", i), outq[i], e_ramp[i]);
        check("ramp_ur3", urq[3], 0);
        check("ramp_ur7", urq[7], 1);
        check("ramp_ur11", urq[11], 1);
        check("ramp_ur_total", ur_total - ur_base, 2);

        // Small negative step with starvation
        reset_mid("down");
        push(0);
        push(-4);
        wait_outs("down", 12);
        for (int i = 0; i < 8; i++) check($sformatf("down_out%0d", i), outq[i], e_down[i]);
        check("down_ur3", urq[3], 1);
        check("down_ur4", urq[4], 0);
        check("down_ur7", urq[7], 1);
        check("down_ur11", urq[11], 1);
        check("down_ur_total", ur_total - ur_base, 3);

        // Full-scale swing: no wrap
        reset_mid("ext");
        push(-32768);
        push(32767);
        wait_outs("ext", 8);
        for (int i = 0; i < 5; i++) check($sformatf("ext_out%0d", i), outq[i], e_ext[i]);
        for (int i = 1; i < 8; i++) check($sformatf("ext_mono%0d", i), outq[i] >= outq[i-1], 1);

        // Continuous s_valid: data tracks accepted count, 10 per output step
        reset_mid("stream");
        s_if.s_data  = '0;
        s_if.s_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            s_if.s_data = BW'(40 * accq.size());
        end
        s_if.s_valid = 1'b0;
        check("stream_n_acc", accq.size() >= 10, 1);
        for (int i = 0; i < accq.size(); i++) check($sformatf("stream_acc%0d", i), accq[i], 40 * i);
        check("stream_gap1", acc_cyc[1] - acc_cyc[0], 2);
        check("stream_gap2", acc_cyc[2] - acc_cyc[1], 2);
        for (int i = 3; i < accq.size(); i++)
            check($sformatf("stream_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 4);
        wait_outs("stream", 24);
        for (int i = 0; i < 24; i++) check($sformatf("stream_out%0d", i), outq[i], 10 * i);
        begin
            int ur_sum = 0;
            for (int i = 0; i < 24; i++) ur_sum += int'(urq[i]);
            check("stream_no_underrun", ur_sum, 0);
        end

        // Freeze for 7 cycles after two outputs
        reset_mid("frz");
        push(0);
        push(400);
        wait_outs("frz_pre", 2);
        ena          = 1'b0;
        s_if.s_valid = 1'b1;
        s_if.s_data  = BW'(999);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("frz_valid%0d", c), interp_valid_o, 0);
            check($sformatf("frz_hold%0d", c), interp_o, 100);
            check($sformatf("frz_ready%0d", c), s_if.s_ready, 0);
            check($sformatf("frz_ur%0d", c), underrun_o, 0);
        end
        s_if.s_valid = 1'b0;
        ena          = 1'b1;
        wait_outs("frz", 8);
        for (int i = 0; i < 8; i++) check($sformatf("frz_out%0d", i), outq[i], e_ramp[i]);
        check("frz_n_acc", accq.size(), 2);

        // Reset mid-RUN: two fresh samples needed before output resumes
        reset_mid("rst");
        push(1000);
        repeat (10) @(negedge clk);
        check("rst_one_sample_outs", outq.size(), 0);
        check("rst_one_sample_valid", interp_valid_o, 0);
        push(2000);
        wait_outs("rst", 2);
        check("rst_first", outq[0], 1000);
        check("rst_second", outq[1], 1250);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
